fi_emr_unloader: RTL and testbench
==================================

Name: fi_emr_unloader

Overview:
- Upstream feeder for the fault-injection block. On each CRC error event it unloads the device Error Message Register (EMR) through the serial EMR port.
- Delivers the result as a parallel emr_data word with a one-cycle emr_valid strobe, matching the emr_data/emr_valid inputs of the fault-injection stage.
- Sits between the CRC/EMR primitive interface and the fault-injection/scrub logic.

Parameters:
- EMR_WIDTH, 67, EMR bits unloaded per event; also the width of emr_data.
- OVR_CNT_WIDTH, 8, width of the saturating overrun counter.

Ports:
- clk  input  1  sole clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  when low, new CRC error events are ignored; a transfer already in progress completes.
- crc_error  input  1  level error flag from the CRC check; only the rising edge triggers.
- emr_regout  input  1  serial EMR data from the primitive; LSB (bit 0) is presented first.
- emr_shiftnld  output  1  0 = parallel load of the EMR into the shift chain, 1 = shift.
- emr_shift_en  output  1  shift-chain clock enable to the primitive.
- emr_data  output  EMR_WIDTH  last unloaded EMR word; held until the next completion.
- emr_valid  output  1  one-cycle strobe marking a new emr_data.
- busy  output  1  high whenever state != IDLE.
- overrun_cnt  output  OVR_CNT_WIDTH  count of events dropped while busy; saturates.

Behaviour:
- Reset values:
  - emr_data = 0, emr_valid = 0, busy = 0, overrun_cnt = 0.
  - emr_shiftnld = 1, emr_shift_en = 0.
  - State = IDLE, bit counter = 0, shift register = 0, crc_error_d = 0.
- Edge detect:
  - crc_error_d is a registered copy of crc_error; rise = crc_error & ~crc_error_d.
  - A level held high never retriggers. crc_error_d updates every cycle, including while busy.
- States (IDLE, LOAD, SHIFT, DONE):
  - IDLE: if rise & enable, go to LOAD. Otherwise stay.
  - LOAD (1 cycle): emr_shiftnld = 0, emr_shift_en = 1. The primitive captures the EMR and presents bit 0 on emr_regout from the next cycle. Go to SHIFT; counter = 0.
  - SHIFT (EMR_WIDTH cycles): emr_shiftnld = 1, emr_shift_en = 1.
    - Each cycle: sreg <= {emr_regout, sreg[EMR_WIDTH-1:1]}; counter increments.
    - When counter == EMR_WIDTH-1, go to DONE. Bit 0 ends up in sreg[0].
  - DONE (1 cycle): emr_shift_en = 0; emr_data <= sreg; emr_valid = 1 in the following cycle; go to IDLE.
- Outputs are registered. With the first high sample of crc_error at cycle N:
  - LOAD is at N+1.
  - SHIFT spans N+2 to N+EMR_WIDTH+1.
  - DONE is at N+EMR_WIDTH+2.
  - emr_valid and the new emr_data are visible at N+EMR_WIDTH+3.
- Back-to-back events: an event in the same cycle as emr_valid is accepted. busy drops for that cycle, and LOAD follows next cycle.
- Overrun:
  - A rise while state != IDLE, with enable high, increments overrun_cnt.
  - It does not restart or disturb the transfer in progress.
  - Saturates at all-ones with no wrap.
  - A rise with enable low is ignored and not counted.
- enable falling mid-transfer: the transfer completes normally.
- rst mid-transfer: all registers return to reset values next cycle. No emr_valid for the aborted transfer.
- The counter width is clog2(EMR_WIDTH), minimum 1. Comparisons are done at counter width; there is no arithmetic wrap.

Decomposition:
- Package fi_emr_pkg holds:
  - state enum fi_emr_state_t {IDLE, LOAD, SHIFT, DONE};
  - constant FI_EMR_WIDTH_DEFAULT = 67;
  - a clog2-based counter width function.
- Single module; no sub-module is warranted. The edge detect and counter stay inline.

Test Plan:
- Single event: EMR model loaded with 67'h5_A5A5_0000_DEAD_BEEF, crc_error rises at cycle 10 → emr_shiftnld low only at cycle 11; emr_shift_en high at cycles 11–78; emr_valid single pulse at cycle 80; emr_data = 67'h5_A5A5_0000_DEAD_BEEF; busy high for cycles 11–79.
- Held level: crc_error held high for 300 cycles → exactly one emr_valid; overrun_cnt = 0.
- Overrun: second rise at cycle 40 during the first transfer → first word is still correct; overrun_cnt = 1; no second transfer. 300 mid-transfer rises → overrun_cnt saturates at 255.
- Back-to-back: second rise exactly at the emr_valid cycle, with pattern 67'h0 then 67'h7_FFFF_FFFF_FFFF_FFFF → two valid strobes 70 cycles apart with correct words; overrun_cnt = 0.
- Enable gating: rise with enable = 0 → no LOAD, no count. enable dropped at cycle 30 of a transfer → transfer completes with the correct emr_data.
- Mid-transfer reset: rst pulsed at SHIFT cycle 20 → next cycle all outputs at reset values; no emr_valid; a fresh rise afterwards unloads correctly.

Source files
------------

// File: rtl/fi_emr_pkg.sv
// fi_emr_pkg: state type and sizing helpers shared by the EMR unloader
package fi_emr_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} fi_emr_state_t;
   localparam int FI_EMR_WIDTH_DEFAULT = 67;
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/fi_emr_unloader.sv
// fi_emr_unloader: on each CRC error rising edge, serially unloads the EMR and presents it as a parallel word
module fi_emr_unloader
   import fi_emr_pkg::*;
#(
   parameter int EMR_WIDTH     = FI_EMR_WIDTH_DEFAULT,
   parameter int OVR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     crc_error,
   input  logic                     emr_regout,
   output logic                     emr_shiftnld,
   output logic                     emr_shift_en,
   output logic [EMR_WIDTH-1:0]     emr_data,
   output logic                     emr_valid,
   output logic                     busy,
   output logic [OVR_CNT_WIDTH-1:0] overrun_cnt
);
   localparam int CW = cnt_width(EMR_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(EMR_WIDTH - 1);

   fi_emr_state_t            state_q;
   logic [CW-1:0]            cnt_q;
   logic [EMR_WIDTH-1:0]     sreg_q, data_q;
   logic [OVR_CNT_WIDTH-1:0] ovr_q;
   logic                     crc_error_q, valid_q, shiftnld_q, shift_en_q, busy_q;
   logic                     rise;

   assign rise = crc_error & ~crc_error_q & enable;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sreg_q      <= '0;
         data_q      <= '0;
         ovr_q       <= '0;
         crc_error_q <= 1'b0;
         valid_q     <= 1'b0;
         shiftnld_q  <= 1'b1;
         shift_en_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         crc_error_q <= crc_error;
         valid_q     <= 1'b0;
         // events arriving mid-transfer are counted but never restart the unload
         if (rise && state_q != IDLE && ovr_q != '1)
            ovr_q <= ovr_q + 1'b1;
         case (state_q)
            IDLE: if (rise) begin
               state_q    <= LOAD;
               shiftnld_q <= 1'b0;
               shift_en_q <= 1'b1;
               busy_q     <= 1'b1;
            end
            LOAD: begin
               state_q    <= SHIFT;
               cnt_q      <= '0;
               shiftnld_q <= 1'b1;
            end
            SHIFT: begin
               sreg_q <= {emr_regout, sreg_q[EMR_WIDTH-1:1]};
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q    <= DONE;
                  shift_en_q <= 1'b0;
               end
            end
            DONE: begin
               data_q  <= sreg_q;
               valid_q <= 1'b1;
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign emr_shiftnld = shiftnld_q;
   assign emr_shift_en = shift_en_q;
   assign emr_data     = data_q;
   assign emr_valid    = valid_q;
   assign busy         = busy_q;
   assign overrun_cnt  = ovr_q;
endmodule

// File: tb/tb_fi_emr_unloader.sv
// tb_fi_emr_unloader: EMR primitive model plus timing-based reference model of the unloader
module tb_fi_emr_unloader;
   localparam int W  = 67;
   localparam int OW = 8;
   localparam int OMAX = (1 << OW) - 1;

   logic clk = 1'b0, rst = 1'b1, enable = 1'b0, crc_error = 1'b0;
   logic emr_regout, emr_shiftnld, emr_shift_en, emr_valid, busy;
   logic [W-1:0]  emr_data;
   logic [W-1:0]  emr_word = '0, chain = '0;
   logic [OW-1:0] overrun_cnt;
   int  cyc = 0, tests = 0, fails = 0, vcount = 0;
   bit  chk_on = 1'b0;
   bit  m_act = 1'b0, m_prev = 1'b0;
   int  m_s = 0, m_ovr = 0;
   logic [W-1:0] m_cap = '0, m_data = '0;

   fi_emr_unloader #(.EMR_WIDTH(W), .OVR_CNT_WIDTH(OW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .crc_error(crc_error),
      .emr_regout(emr_regout), .emr_shiftnld(emr_shiftnld), .emr_shift_en(emr_shift_en),
      .emr_data(emr_data), .emr_valid(emr_valid), .busy(busy), .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   // EMR primitive: parallel load when shiftnld low, shift right otherwise
   assign emr_regout = chain[0];
   always @(posedge clk) if (emr_shift_en) chain <= emr_shiftnld ? (chain >> 1) : emr_word;

   // transfer started at end of period s: LOAD s+1, SHIFT s+2..s+W+1, DONE s+W+2, valid s+W+3
   function automatic bit in_rng(int p, int lo, int hi);
      return m_act && p >= m_s + lo && p <= m_s + hi;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_act = 1'b0; m_prev = 1'b0; m_ovr = 0; m_data = '0; chk_on = 1'b1;
      end else begin
         if (in_rng(cyc, W + 2, W + 2)) m_data = m_cap;
         if (in_rng(cyc, 1, 1)) m_cap = emr_word;
         if (crc_error && !m_prev && enable) begin
            if (in_rng(cyc, 1, W + 2)) m_ovr = (m_ovr < OMAX) ? m_ovr + 1 : m_ovr;
            else begin m_act = 1'b1; m_s = cyc; end
         end
         m_prev = crc_error;
      end
      cyc++;
   end

   task automatic chk(string n, logic [127:0] got, logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
      end
   endtask

   always @(negedge clk) if (chk_on) begin
      if (emr_valid === 1'b1) vcount++;
      chk("busy", busy, in_rng(cyc, 1, W + 2));
      chk("shiftnld", emr_shiftnld, !in_rng(cyc, 1, 1));
      chk("shift_en", emr_shift_en, in_rng(cyc, 1, W + 1));
      chk("valid", emr_valid, in_rng(cyc, W + 3, W + 3));
      chk("data", emr_data, m_data);
      chk("overrun", overrun_cnt, m_ovr);
   end

   task automatic go(int n);
      while (cyc < n) begin @(posedge clk); #1; end
   endtask

   task automatic at(int n);
      go(n);
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] rnd();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int v0, p0, p1, k, it;
      logic [W-1:0] w;
      go(3); rst = 1'b0; enable = 1'b1;
      emr_word = 67'h5_A5A5_0000_DEAD_BEEF;
      go(10); crc_error = 1'b1;
      at(11);
      chk("t1_nld_low", emr_shiftnld, 1'b0);
      chk("t1_busy11", busy, 1'b1);
      chk("t1_en11", emr_shift_en, 1'b1);
      go(12); crc_error = 1'b0;
      at(12); chk("t1_nld_hi", emr_shiftnld, 1'b1);
      at(78); chk("t1_en78", emr_shift_en, 1'b1);
      at(79);
      chk("t1_en79", emr_shift_en, 1'b0);
      chk("t1_busy79", busy, 1'b1);
      chk("t1_valid79", emr_valid, 1'b0);
      at(80);
      chk("t1_valid80", emr_valid, 1'b1);
      chk("t1_data", emr_data, 67'h5_A5A5_0000_DEAD_BEEF);
      chk("t1_busy80", busy, 1'b0);
      at(81); chk("t1_valid81", emr_valid, 1'b0);

      go(100); v0 = vcount; crc_error = 1'b1;
      go(400); crc_error = 1'b0;
      chk("t2_one_valid", vcount - v0, 1);
      chk("t2_ovr", overrun_cnt, 0);

      emr_word = {3'h2, 64'h0123_4567_89AB_CDEF};
      go(450); v0 = vcount; crc_error = 1'b1;
      go(452); crc_error = 1'b0;
      go(480); crc_error = 1'b1;
      go(482); crc_error = 1'b0;
      at(520);
      chk("t3_ovr1", overrun_cnt, 1);
      chk("t3_valid", emr_valid, 1'b1);
      chk("t3_data", emr_data, {3'h2, 64'h0123_4567_89AB_CDEF});
      go(650); chk("t3_one_valid", vcount - v0, 1);

      go(700); k = 0; it = 0;
      while (k < 300 && it < 2000) begin
         if (busy === 1'b1) k++;
         crc_error = 1'b1; go(cyc + 1);
         crc_error = 1'b0; go(cyc + 1);
         it++;
      end
      chk("t3_pulse_budget", it < 2000, 1'b1);
      go(cyc + 100);
      chk("t3_sat", overrun_cnt, 8'hFF);
      rst = 1'b1; go(cyc + 1); rst = 1'b0;

      p0 = cyc + 5;
      go(p0); emr_word = '0; crc_error = 1'b1;
      go(p0 + 2); crc_error = 1'b0; emr_word = '1;
      go(p0 + 70); crc_error = 1'b1;
      at(p0 + 70);
      chk("t4_valid1", emr_valid, 1'b1);
      chk("t4_data1", emr_data, 67'h0);
      chk("t4_busy_gap", busy, 1'b0);
      at(p0 + 71); chk("t4_reload", emr_shiftnld, 1'b0);
      go(p0 + 72); crc_error = 1'b0;
      at(p0 + 140);
      chk("t4_valid2", emr_valid, 1'b1);
      chk("t4_data2", emr_data, 67'h7_FFFF_FFFF_FFFF_FFFF);
      chk("t4_ovr0", overrun_cnt, 0);

      p0 = cyc + 5; enable = 1'b0;
      go(p0); crc_error = 1'b1;
      at(p0 + 1);
      chk("t5_no_busy", busy, 1'b0);
      chk("t5_no_load", emr_shiftnld, 1'b1);
      go(p0 + 2); crc_error = 1'b0;
      chk("t5_no_count", overrun_cnt, 0);
      p1 = p0 + 10; w = rnd(); emr_word = w; enable = 1'b1;
      go(p1); crc_error = 1'b1;
      go(p1 + 2); crc_error = 1'b0;
      go(p1 + 20); enable = 1'b0;
      at(p1 + 70);
      chk("t5_valid", emr_valid, 1'b1);
      chk("t5_data", emr_data, w);
      go(p1 + 75); enable = 1'b1;

      p0 = cyc + 5; w = rnd(); emr_word = w;
      go(p0); crc_error = 1'b1;
      go(p0 + 2); crc_error = 1'b0; v0 = vcount;
      go(p0 + 22); rst = 1'b1;
      go(p0 + 23); rst = 1'b0;
      at(p0 + 23);
      chk("t6_busy", busy, 1'b0);
      chk("t6_en", emr_shift_en, 1'b0);
      chk("t6_nld", emr_shiftnld, 1'b1);
      chk("t6_valid", emr_valid, 1'b0);
      chk("t6_data", emr_data, 67'h0);
      go(p0 + 120); chk("t6_no_valid", vcount - v0, 0);
      p1 = p0 + 125;
      go(p1); crc_error = 1'b1;
      go(p1 + 2); crc_error = 1'b0;
      at(p1 + 70);
      chk("t6_valid2", emr_valid, 1'b1);
      chk("t6_data2", emr_data, w);

      for (int i = 0; i < 3000; i++) begin
         go(cyc + 1);
         crc_error = $urandom_range(0, 9) < 3;
         enable    = $urandom_range(0, 7) != 0;
         rst       = $urandom_range(0, 299) == 0;
         if ($urandom_range(0, 15) == 0) emr_word = rnd();
      end
      go(cyc + 1); rst = 1'b0; crc_error = 1'b0;
      go(cyc + 100);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
